// File: rtl/funrv32_rf_wb_arbiter_if.sv
// Writeback request channel: one requester's valid/ready handshake carrying a
// destination register and data. master = requester side, slave = arbiter side.
interface funrv32_rf_wb_arbiter_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            valid;
  logic            ready;
  logic [AW-1:0]   addr;
  logic [XLEN-1:0] data;

  modport master (
    output valid,
    output addr,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  addr,
    input  data,
    output ready
  );
endinterface

// File: rtl/funrv32_rf_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port between A (ALU) and B (load);
// accept at edge N writes at N+1, losers wait with valid held, no ready during the clear sweep.
module funrv32_rf_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NREG = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  funrv32_rf_wb_arbiter_if.slave  a,
  funrv32_rf_wb_arbiter_if.slave  b,
  output logic                    rf_we,
  output logic [AW-1:0]           rf_ad,
  output logic [XLEN-1:0]         rf_rd,
  output logic                    init_done
);

  typedef enum logic {INIT, RUN} state_t;
  typedef enum logic {GNT_A, GNT_B} grant_t;

  state_t        state;
  grant_t        last_grant;
  logic [AW-1:0] cnt;

  // Contention goes to whichever requester was not served last.
  assign a.ready = (state == RUN) && a.valid && (!b.valid || (last_grant == GNT_B));
  assign b.ready = (state == RUN) && b.valid && (!a.valid || (last_grant == GNT_A));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= INIT;
      last_grant <= GNT_B;
      cnt        <= '0;
      rf_we      <= 1'b0;
      rf_ad      <= '0;
      rf_rd      <= '0;
      init_done  <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          rf_we <= 1'b1;
          rf_ad <= cnt;
          rf_rd <= '0;
          cnt   <= cnt + 1'b1;
          if (cnt == AW'(NREG - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          // x0 requests are consumed but never reach the regfile.
          if (a.ready) begin
            last_grant <= GNT_A;
            rf_we      <= (a.addr != '0);
            if (a.addr != '0) begin
              rf_ad <= a.addr;
              rf_rd <= a.data;
            end
          end else if (b.ready) begin
            last_grant <= GNT_B;
            rf_we      <= (b.addr != '0);
            if (b.addr != '0) begin
              rf_ad <= b.addr;
              rf_rd <= b.data;
            end
          end else begin
            rf_we <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_funrv32_rf_wb_arbiter.sv
// Scoreboard bench: expected regfile writes are queued as requests are accepted
// and a negedge monitor pops and compares every write the arbiter emits.
module tb_funrv32_rf_wb_arbiter;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  funrv32_rf_wb_arbiter_if #(.XLEN(XLEN), .AW(AW)) a_if ();
  funrv32_rf_wb_arbiter_if #(.XLEN(XLEN), .AW(AW)) b_if ();

  logic            rf_we;
  logic [AW-1:0]   rf_ad;
  logic [XLEN-1:0] rf_rd;
  logic            init_done;

  funrv32_rf_wb_arbiter #(.XLEN(XLEN), .AW(AW), .NREG(NREG)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a_if.slave),
    .b         (b_if.slave),
    .rf_we     (rf_we),
    .rf_ad     (rf_ad),
    .rf_rd     (rf_rd),
    .init_done (init_done)
  );

  typedef struct packed {
    logic [AW-1:0]   ad;
    logic [XLEN-1:0] rd;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [AW-1:0] ad, input logic [XLEN-1:0] rd);
    wr_t e;
    e.ad = ad;
    e.rd = rd;
    exp_q.push_back(e);
  endtask

  task automatic push_sweep(input int n);
    for (int i = 0; i < n; i++) push_wr(AW'(i), '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write the DUT presents must match the head of the queue.
  always @(negedge clk) begin
    wr_t e;
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got write x%0d=0x%0h expected no write", rf_ad, rf_rd);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(rf_ad), 32'(e.ad));
        check("wr_data", rf_rd, e.rd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_a;
    a_if.valid = 1'b0; a_if.addr = '0; a_if.data = '0;
    b_if.valid = 1'b0; b_if.addr = '0; b_if.data = '0;
    reset = 1'b1;
    step();
    step();

    @(negedge clk);
    check("rst_we",        32'(rf_we),     32'd0);
    check("rst_ad",        32'(rf_ad),     32'd0);
    check("rst_rd",        rf_rd,          32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);

    // Reset mid-init: sweep writes x0..x9, reset lands when cnt=10.
    @(posedge clk); #1;
    reset = 1'b0;
    push_sweep(10);
    repeat (10) step();
    reset = 1'b1;
    step();
    @(negedge clk);
    check("midinit_we",        32'(rf_we),     32'd0);
    check("midinit_init_done", 32'(init_done), 32'd0);

    // Full sweep with both requesters pending the whole time.
    a_if.valid = 1'b1; a_if.addr = 5'd3; a_if.data = 32'h11;
    b_if.valid = 1'b1; b_if.addr = 5'd4; b_if.data = 32'h22;
    @(posedge clk); #1;
    reset = 1'b0;
    push_sweep(NREG);
    for (int i = 0; i < NREG; i++) begin
      @(negedge clk);
      check("init_a_ready",   32'(a_if.ready), 32'd0);
      check("init_b_ready",   32'(b_if.ready), 32'd0);
      check("init_done_low",  32'(init_done),  32'd0);
      @(posedge clk); #1;
    end

    // Continuous contention: A first, then strict alternation.
    for (int i = 0; i < 6; i++) begin
      exp_a = ((i % 2) == 0);
      @(negedge clk);
      if (i == 0) check("init_done_high", 32'(init_done), 32'd1);
      check("cont_a_ready", 32'(a_if.ready), 32'(exp_a));
      check("cont_b_ready", 32'(b_if.ready), 32'(!exp_a));
      if (exp_a) push_wr(a_if.addr, a_if.data);
      else       push_wr(b_if.addr, b_if.data);
      @(posedge clk); #1;
      if (exp_a) a_if.data = a_if.data + 32'd1;
      else       b_if.data = b_if.data + 32'd1;
    end
    a_if.valid = 1'b0;
    b_if.valid = 1'b0;
    step();

    // Single write from A.
    a_if.valid = 1'b1; a_if.addr = 5'd5; a_if.data = 32'hDEADBEEF;
    @(negedge clk);
    check("single_a_ready", 32'(a_if.ready), 32'd1);
    check("single_b_ready", 32'(b_if.ready), 32'd0);
    push_wr(5'd5, 32'hDEADBEEF);
    @(posedge clk); #1;
    a_if.valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("single_we_after", 32'(rf_we), 32'd0);
    check("single_ad_hold",  32'(rf_ad), 32'd5);
    check("single_rd_hold",  rf_rd,      32'hDEADBEEF);

    // x0 drop from B: accepted, no write, and B becomes last_grant.
    @(posedge clk); #1;
    b_if.valid = 1'b1; b_if.addr = 5'd0; b_if.data = 32'hFFFFFFFF;
    @(negedge clk);
    check("x0_b_ready", 32'(b_if.ready), 32'd1);
    check("x0_a_ready", 32'(a_if.ready), 32'd0);
    @(posedge clk); #1;
    b_if.valid = 1'b0;
    @(negedge clk);
    check("x0_we", 32'(rf_we), 32'd0);

    // Contention after the x0 grant goes to A.
    @(posedge clk); #1;
    a_if.valid = 1'b1; a_if.addr = 5'd9;  a_if.data = 32'h99;
    b_if.valid = 1'b1; b_if.addr = 5'd10; b_if.data = 32'hAA;
    @(negedge clk);
    check("post_x0_a_ready", 32'(a_if.ready), 32'd1);
    check("post_x0_b_ready", 32'(b_if.ready), 32'd0);
    push_wr(5'd9, 32'h99);
    @(posedge clk); #1;
    a_if.valid = 1'b0;
    @(negedge clk);
    check("post_x0_b_ready2", 32'(b_if.ready), 32'd1);
    push_wr(5'd10, 32'hAA);
    @(posedge clk); #1;
    b_if.valid = 1'b0;

    // Reset on the same edge that accepts A(x7): x7 must never be written.
    a_if.valid = 1'b1; a_if.addr = 5'd7; a_if.data = 32'h77;
    reset = 1'b1;
    @(negedge clk);
    check("rst_xfer_a_ready", 32'(a_if.ready), 32'd1);
    @(posedge clk); #1;
    a_if.valid = 1'b0;
    @(negedge clk);
    check("rst_xfer_we",        32'(rf_we),     32'd0);
    check("rst_xfer_init_done", 32'(init_done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    push_sweep(NREG);
    repeat (NREG) step();
    @(negedge clk);
    check("resweep_init_done", 32'(init_done), 32'd1);
    step();
    step();
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
